// File: rtl/seq_bcd_adder_display_pkg.sv
// -----------------------------------------------------------------------------
// seq_bcd_adder_display_pkg
// Shared definitions for the sequential add/subtract + BCD + 7-segment path:
//   state_t     FSM state encoding (IDLE, LOAD, CONV, DONE)
//   SEG_BLANK   active-low pattern with every segment off
//   SEG_MINUS   active-low pattern lighting only segment g
//   bcd_to_seg  BCD digit -> active-low {g,f,e,d,c,b,a}
//   cnt_width   width of the double-dabble iteration counter for a WIDTH
// -----------------------------------------------------------------------------
package seq_bcd_adder_display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CONV = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = ~7'h40;

   // Codes above 9 never occur after a correct conversion; they map to blank.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
      logic [6:0] lit;
      case (digit)
         4'd0:    lit = 7'h3F;
         4'd1:    lit = 7'h06;
         4'd2:    lit = 7'h5B;
         4'd3:    lit = 7'h4F;
         4'd4:    lit = 7'h66;
         4'd5:    lit = 7'h6D;
         4'd6:    lit = 7'h7D;
         4'd7:    lit = 7'h07;
         4'd8:    lit = 7'h7F;
         4'd9:    lit = 7'h67;
         default: lit = 7'h00;
      endcase
      return ~lit;
   endfunction

   // Counter must be able to hold WIDTH+1 (the iteration count).
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/seq_bcd_adder_display_enc.sv
// -----------------------------------------------------------------------------
// bcd_seg7_enc
// Combinational encoder for one display digit.
//   digit  in  4  BCD digit value
//   blank  in  1  force all segments off
//   minus  in  1  show the minus sign instead of the digit (wins over blank)
//   seg    out 7  active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module bcd_seg7_enc
   import seq_bcd_adder_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       blank,
   input  logic       minus,
   output logic [6:0] seg
);

   always_comb begin
      seg = bcd_to_seg(digit);
      if (minus) begin
         seg = SEG_MINUS;
      end else if (blank) begin
         seg = SEG_BLANK;
      end
   end

endmodule

// File: rtl/seq_bcd_adder_display.sv
// -----------------------------------------------------------------------------
// seq_bcd_adder_display
// Registered add / absolute-subtract unit with an iterative double-dabble
// binary-to-BCD converter (one shift per clock) and 7-segment digit outputs.
//   CLOCK_50 in  1          clock, rising edge
//   rst_n    in  1          synchronous reset, active-low
//   start    in  1          request, accepted only while idle
//   sub      in  1          0: a+b, 1: |a-b|  (sampled with start)
//   a, b     in  WIDTH      operands (sampled with start)
//   busy     out 1          operation in progress
//   done     out 1          one-cycle pulse, results valid from this cycle
//   neg      out 1          result negative (sub=1 and a<b)
//   sum      out WIDTH+1    binary magnitude
//   bcd      out 4*DIGITS   BCD magnitude, digit k = bcd[4k+3:4k]
//   seg      out 7*DIGITS   active-low segments, digit k = seg[7k+6:7k]
// -----------------------------------------------------------------------------
module seq_bcd_adder_display
   import seq_bcd_adder_display_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DIGITS   = 3,
   parameter bit BLANK_LZ = 1'b1
)
(
   input  logic                  CLOCK_50,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic [WIDTH:0]        sum,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int RES_W = WIDTH + 1;
   localparam int BCD_W = 4 * DIGITS;
   localparam int SEG_W = 7 * DIGITS;
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, a_next, b_reg, b_next;
   logic               sub_reg, sub_next;
   logic [RES_W-1:0]   r_reg, r_next;
   logic               n_reg, n_next;
   logic [BCD_W-1:0]   acc_reg, acc_next;
   logic [RES_W-1:0]   bin_reg, bin_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               busy_reg, busy_next;
   logic               done_reg, done_next;
   logic               neg_reg, neg_next;
   logic [RES_W-1:0]   sum_reg, sum_next;
   logic [BCD_W-1:0]   bcd_reg, bcd_next;
   logic [SEG_W-1:0]   seg_reg, seg_next;

   logic [BCD_W-1:0]   acc_adj;
   logic [SEG_W-1:0]   seg_enc;
   logic [DIGITS-1:0]  shown;
   logic [DIGITS-1:0]  minus_d;

   // Double-dabble correction: any digit >= 5 gets +3 before the shift so
   // that the shift carries it into the next decade correctly.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ?
                                     acc_reg[4*gi +: 4] + 4'd3 : acc_reg[4*gi +: 4];
      end
   endgenerate

   // Display decode works on the finished conversion; it is only captured in
   // DONE, when acc_reg holds the final BCD value.
   // A digit is shown if it or any digit above it is nonzero (digit 0 always).
   // The minus sign goes on the first blanked digit above the top shown one.
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         if (gi == 0) begin : g_lsd
            assign shown[gi]   = 1'b1;
            assign minus_d[gi] = 1'b0;
         end else begin : g_upper
            assign shown[gi]   = !BLANK_LZ || (|acc_reg[BCD_W-1:4*gi]);
            assign minus_d[gi] = BLANK_LZ && n_reg && !shown[gi] && shown[gi-1];
         end

         bcd_seg7_enc u_enc (
            .digit (acc_reg[4*gi +: 4]),
            .blank (!shown[gi]),
            .minus (minus_d[gi]),
            .seg   (seg_enc[7*gi +: 7])
         );
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sub_next   = sub_reg;
      r_next     = r_reg;
      n_next     = n_reg;
      acc_next   = acc_reg;
      bin_next   = bin_reg;
      cnt_next   = cnt_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      neg_next   = neg_reg;
      sum_next   = sum_reg;
      bcd_next   = bcd_reg;
      seg_next   = seg_reg;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               a_next     = a;
               b_next     = b;
               sub_next   = sub;
               busy_next  = 1'b1;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (!sub_reg) begin
               r_next = {1'b0, a_reg} + {1'b0, b_reg};
               n_next = 1'b0;
            end else if (a_reg >= b_reg) begin
               r_next = {1'b0, a_reg - b_reg};
               n_next = 1'b0;
            end else begin
               r_next = {1'b0, b_reg - a_reg};
               n_next = 1'b1;
            end
            acc_next   = '0;
            bin_next   = r_next;
            cnt_next   = '0;
            state_next = ST_CONV;
         end
         ST_CONV: begin
            {acc_next, bin_next} = {acc_adj, bin_reg} << 1;
            cnt_next             = cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_ITER) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            sum_next   = r_reg;
            neg_next   = n_reg;
            bcd_next   = acc_reg;
            seg_next   = seg_enc;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sub_reg   <= 1'b0;
         r_reg     <= '0;
         n_reg     <= 1'b0;
         acc_reg   <= '0;
         bin_reg   <= '0;
         cnt_reg   <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         neg_reg   <= 1'b0;
         sum_reg   <= '0;
         bcd_reg   <= '0;
         seg_reg   <= {DIGITS{SEG_BLANK}};
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sub_reg   <= sub_next;
         r_reg     <= r_next;
         n_reg     <= n_next;
         acc_reg   <= acc_next;
         bin_reg   <= bin_next;
         cnt_reg   <= cnt_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         neg_reg   <= neg_next;
         sum_reg   <= sum_next;
         bcd_reg   <= bcd_next;
         seg_reg   <= seg_next;
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;
   assign neg  = neg_reg;
   assign sum  = sum_reg;
   assign bcd  = bcd_reg;
   assign seg  = seg_reg;

endmodule

// File: tb/tb_seq_bcd_adder_display.sv
// -----------------------------------------------------------------------------
// tb_seq_bcd_adder_display
// Directed vectors with hand-computed results. Stimulus pushes the expected
// result into a queue; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_seq_bcd_adder_display;

   logic        CLOCK_50 = 1'b0;
   logic        rst_n    = 1'b0;
   logic        start    = 1'b0;
   logic        sub      = 1'b0;
   logic [7:0]  a        = 8'd0;
   logic [7:0]  b        = 8'd0;
   logic        busy, done, neg;
   logic [8:0]  sum;
   logic [11:0] bcd;
   logic [20:0] seg;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          id;
      logic [8:0]  sum;
      logic        neg;
      logic [11:0] bcd;
      logic [20:0] seg;
   } exp_t;

   exp_t exp_q[$];

   localparam logic [6:0] P0 = ~7'h3F;
   localparam logic [6:0] P1 = ~7'h06;
   localparam logic [6:0] P2 = ~7'h5B;
   localparam logic [6:0] P3 = ~7'h4F;
   localparam logic [6:0] P4 = ~7'h66;
   localparam logic [6:0] P5 = ~7'h6D;
   localparam logic [6:0] P8 = ~7'h7F;
   localparam logic [6:0] P9 = ~7'h67;
   localparam logic [6:0] PB = 7'h7F;
   localparam logic [6:0] PM = ~7'h40;

   seq_bcd_adder_display #(
      .WIDTH    (8),
      .DIGITS   (3),
      .BLANK_LZ (1'b1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .neg      (neg),
      .sum      (sum),
      .bcd      (bcd),
      .seg      (seg)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge CLOCK_50);
         if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=done required=no_done sum=%0d", sum);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("op%0d_sum", e.id), 32'(sum), 32'(e.sum));
               check($sformatf("op%0d_neg", e.id), 32'(neg), 32'(e.neg));
               check($sformatf("op%0d_bcd", e.id), 32'(bcd), 32'(e.bcd));
               check($sformatf("op%0d_seg", e.id), 32'(seg), 32'(e.seg));
               check($sformatf("op%0d_busy_at_done", e.id), 32'(busy), 32'd0);
               $display("TXN op%0d sum=%0d neg=%0d bcd=%03h seg=%06h", e.id, sum, neg, bcd, seg);
            end
         end
      end
   end

   // Counts edges until done is seen at the following negedge.
   task automatic wait_done(input string name, output int k);
      k = 0;
      while (k < 40) begin
         @(posedge CLOCK_50);
         k++;
         @(negedge CLOCK_50);
         if (done === 1'b1) break;
      end
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done required=done", name);
      end
   endtask

   task automatic push(input int id, input logic [8:0] s, input logic n,
                       input logic [11:0] d, input logic [20:0] sg);
      exp_t e;
      e.id = id; e.sum = s; e.neg = n; e.bcd = d; e.seg = sg;
      exp_q.push_back(e);
   endtask

   task automatic run_op(input int id, input logic [7:0] av, input logic [7:0] bv,
                         input logic sv, input logic [8:0] s, input logic n,
                         input logic [11:0] d, input logic [20:0] sg);
      int k;
      push(id, s, n, d, sg);
      @(posedge CLOCK_50);
      #1;
      a = av; b = bv; sub = sv; start = 1'b1;
      @(posedge CLOCK_50);
      #1;
      start = 1'b0;
      check($sformatf("op%0d_busy_after_accept", id), 32'(busy), 32'd1);
      wait_done($sformatf("op%0d", id), k);
      check($sformatf("op%0d_latency", id), 32'(k), 32'd11);
   endtask

   initial begin
      int k;
      int nd;

      // Reset held for two edges
      rst_n = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_neg",  32'(neg),  32'd0);
      check("rst_sum",  32'(sum),  32'd0);
      check("rst_bcd",  32'(bcd),  32'h000);
      check("rst_seg",  32'(seg),  32'({PB, PB, PB}));
      @(posedge CLOCK_50);
      #1;
      rst_n = 1'b1;

      run_op(1, 8'd255, 8'd255, 1'b0, 9'd510, 1'b0, 12'h510, {P5, P1, P0});
      run_op(2, 8'd3,   8'd10,  1'b1, 9'd7,   1'b1, 12'h007, {PB, PM, 7'(~7'h07)});
      run_op(3, 8'd0,   8'd0,   1'b1, 9'd0,   1'b0, 12'h000, {PB, PB, P0});
      run_op(4, 8'd200, 8'd200, 1'b1, 9'd0,   1'b0, 12'h000, {PB, PB, P0});
      run_op(5, 8'd0,   8'd9,   1'b0, 9'd9,   1'b0, 12'h009, {PB, PB, P9});
      run_op(6, 8'd128, 8'd0,   1'b0, 9'd128, 1'b0, 12'h128, {P1, P2, P8});
      run_op(7, 8'd5,   8'd50,  1'b1, 9'd45,  1'b1, 12'h045, {PM, P4, P5});
      run_op(8, 8'd40,  8'd43,  1'b1, 9'd3,   1'b1, 12'h003, {PB, PM, P3});

      // Start during CONV is ignored; then held start gives back-to-back ops
      push(9, 9'd120, 1'b0, 12'h120, {P1, P2, P0});
      @(posedge CLOCK_50);
      #1;
      a = 8'd100; b = 8'd20; sub = 1'b0; start = 1'b1;
      @(posedge CLOCK_50);
      #1;
      start = 1'b0;
      repeat (4) @(posedge CLOCK_50);
      #1;
      a = 8'd1; b = 8'd1; sub = 1'b0; start = 1'b1;
      @(posedge CLOCK_50);
      #1;
      start = 1'b0;
      wait_done("op9", k);
      check("op9_latency_from_ignored_start", 32'(k), 32'd6);
      push(10, 9'd241, 1'b1, 12'h241, {P2, P4, P1});
      a = 8'd9; b = 8'd250; sub = 1'b1; start = 1'b1;
      wait_done("op10", k);
      check("op10_back_to_back_spacing", 32'(k), 32'd12);
      start = 1'b0;
      repeat (3) @(posedge CLOCK_50);

      // Reset in the middle of CONV discards the operation
      @(posedge CLOCK_50);
      #1;
      a = 8'd10; b = 8'd20; sub = 1'b0; start = 1'b1;
      @(posedge CLOCK_50);
      #1;
      start = 1'b0;
      repeat (4) @(posedge CLOCK_50);
      #1;
      rst_n = 1'b0;
      @(posedge CLOCK_50);
      #1;
      rst_n = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_neg",  32'(neg),  32'd0);
      check("midrst_sum",  32'(sum),  32'd0);
      check("midrst_bcd",  32'(bcd),  32'h000);
      check("midrst_seg",  32'(seg),  32'({PB, PB, PB}));
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLOCK_50);
         if (done === 1'b1) nd++;
      end
      check("midrst_no_done", 32'(nd), 32'd0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
